sub_32_serial: RTL and testbench
================================

// Module: sub_32_serial
//
// PURPOSE
//  Bit-serial two's-complement subtractor: computes d = a - b one bit per
//  clock, LSB first, as a + ~b + 1 through a single full-adder cell and a
//  carry flip-flop. Area-lean counterpart to the 32-bit ripple adder, for
//  datapaths that can tolerate multi-cycle latency. Start/busy/done
//  handshake; result and flags held until the next completion.
//
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>= 2)
//
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      asynchronous reset, active-high
//  start       in   1      request: sample a,b and begin (ignored while busy)
//  a           in   WIDTH  minuend, sampled on accepted start
//  b           in   WIDTH  subtrahend, sampled on accepted start
//  busy        out  1      high while state==RUN
//  done        out  1      one-cycle pulse: d and flags just updated
//  d           out  WIDTH  difference a - b (mod 2^WIDTH)
//  borrow_out  out  1      1 when a < b unsigned (= ~final carry)
//  overflow    out  1      signed overflow: (a[MSB]^b[MSB]) & (a[MSB]^d[MSB])
//  zero        out  1      1 when d == 0
//
// BEHAVIOUR
//  - States: IDLE, RUN, DONE. Reset -> IDLE; busy=0, done=0, d=0,
//    borrow_out=0, overflow=0, zero=0; carry ff, bit counter, operand
//    shift registers all cleared.
//  - IDLE: start=1 at edge k -> latch a into A_sr, ~b into B_sr, carry=1,
//    count=0, -> RUN. start=0 -> stay.
//  - RUN: each edge: sum bit = A_sr[0]^B_sr[0]^carry shifted into the MSB of
//    the result shift register; carry <= majority(A_sr[0],B_sr[0],carry);
//    A_sr/B_sr shift right; count++. After WIDTH RUN edges
//    (count==WIDTH-1 at edge) -> DONE.
//  - On the RUN->DONE edge: d <= completed result, borrow_out <= ~carry_out,
//    overflow and zero computed from the latched a/b MSBs and the new d.
//    d and flags change only on this edge.
//  - DONE: done=1 for exactly one cycle. start=1 in DONE is accepted
//    (back-to-back) -> RUN with new operands; otherwise -> IDLE.
//  - Latency: start sampled at edge k -> done high in the cycle after edge
//    k+WIDTH; throughput one op per WIDTH+1 cycles back-to-back.
//  - start while busy=1 is ignored; a/b changes after acceptance have no
//    effect on the result in progress.
//  - Outputs d/flags hold last result through IDLE and the next RUN.
//  - Reset asserted mid-RUN: aborts immediately, all outputs to reset values,
//    no done pulse; first start after release behaves as from IDLE.
//  - borrow_out equals ~carry of the full WIDTH-bit a+~b+1; b=0 gives
//    borrow_out=0 (carry out 1).
//
// TESTING
//  1 a=5, b=3, start one cycle -> busy 32 cycles, done pulse at cycle 33,
//    d=0x00000002, borrow_out=0, overflow=0, zero=0.
//  2 a=3, b=5 -> d=0xFFFFFFFE, borrow_out=1, overflow=0, zero=0.
//  3 a=0x80000000, b=1 -> d=0x7FFFFFFF, overflow=1, borrow_out=0;
//    a=0x7FFFFFFF, b=0xFFFFFFFF -> d=0x80000000, overflow=1, borrow_out=1.
//  4 a=b=0xDEADBEEF -> d=0, zero=1, borrow_out=0; then a=0,b=0 -> zero=1.
//  5 start pulsed again at RUN cycle 10 with other operands -> ignored,
//    result of first op unchanged; start held during DONE -> second op
//    accepted, its done pulse exactly 33 cycles after the first.
//  6 rst asserted at RUN cycle 16 -> busy,done,d,flags 0 asynchronously,
//    no done pulse; fresh op after release returns correct d.

Source files
------------

// File: rtl/sub_32_serial.sv
// Bit-serial two's-complement subtractor: d = a + ~b + 1, LSB first,
// one full-adder cell and a carry flop, start/busy/done handshake.
module sub_32_serial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    count;
  logic             carry;
  logic             a_msb;
  logic             b_msb;
  logic             sum;
  logic             cout;
  logic             accept;
  logic             last;

  assign sum    = a_sr[0] ^ b_sr[0] ^ carry;
  assign cout   = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
  assign res    = {sum, r_sr[WIDTH-1:1]};
  assign accept = start && (state_q != RUN);
  assign last   = (state_q == RUN) && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      r_sr       <= '0;
      count      <= '0;
      carry      <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      d          <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= ~b;
      carry <= 1'b1;
      count <= '0;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (state_q == RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      r_sr  <= res;
      carry <= cout;
      count <= count + 1'b1;
      // final edge: sum is the result MSB, cout the true carry out
      if (last) begin
        d          <= res;
        borrow_out <= ~cout;
        overflow   <= (a_msb ^ b_msb) & (a_msb ^ sum);
        zero       <= (res == '0);
      end
    end
  end

endmodule

// File: tb/tb_sub_32_serial.sv
// Scoreboard bench for sub_32_serial: directed vectors queued at issue,
// monitor pops on each done pulse and checks result, flags and latency.
module tb_sub_32_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] d;
  logic        borrow_out;
  logic        overflow;
  logic        zero;

  typedef struct {
    logic [31:0] d;
    logic        bo;
    logic        ov;
    logic        z;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_fail = 0;

  sub_32_serial #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .d(d), .borrow_out(borrow_out),
    .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", {d, borrow_out, overflow, zero},
            {e.d, e.bo, e.ov, e.z});
        chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(logic [31:0] x, logic [31:0] y, logic [31:0] ed,
                       logic ebo, logic eov, logic ez, bit push);
    exp_t e;
    a = x;
    b = y;
    start = 1'b1;
    if (push) begin
      e = '{ed, ebo, eov, ez, cyc + 33};
      sb.push_back(e);
    end
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 100) begin
      step();
      n++;
    end
    chk("op_complete", 64'(busy | done), 64'd0);
  endtask

  logic [31:0] va [7] = '{32'h5, 32'h3, 32'h80000000, 32'h7FFFFFFF,
                          32'hDEADBEEF, 32'h0, 32'h1};
  logic [31:0] vb [7] = '{32'h3, 32'h5, 32'h1, 32'hFFFFFFFF,
                          32'hDEADBEEF, 32'h0, 32'h0};
  logic [31:0] vd [7] = '{32'h2, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'h80000000,
                          32'h0, 32'h0, 32'h1};
  logic [2:0]  vf [7] = '{3'b000, 3'b100, 3'b010, 3'b110,
                          3'b001, 3'b001, 3'b000};

  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) step();
    chk("reset_state", {busy, done, d, borrow_out, overflow, zero}, 64'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      issue(va[i], vb[i], vd[i], vf[i][2], vf[i][1], vf[i][0], 1'b1);
      chk("busy_after_start", 64'(busy), 64'd1);
      wait_idle();
      step();
    end

    // ignored start mid-run, then back-to-back start held in DONE
    issue(32'h12345678, 32'h1, 32'h12345677, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (9) step();
    chk("d_hold_in_run", 64'(d), 64'h1);
    a = 32'hFFFFFFFF;
    b = 32'h0F0F0F0F;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!done && n < 60) begin
      step();
      n++;
    end
    chk("first_done_seen", 64'(done), 64'd1);
    issue(32'h10, 32'h20, 32'hFFFFFFF0, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_idle();
    step();

    // reset mid-run aborts without a done pulse
    issue(32'h100, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (15) step();
    rst = 1'b1;
    #1;
    chk("async_abort", {busy, done, d, borrow_out, overflow, zero}, 64'd0);
    step();
    step();
    rst = 1'b0;
    step();
    issue(32'h100, 32'h1, 32'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle();
    step();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
